uart_rx_cfg: RTL and testbench

Parametrised successor to the current UART receive path. It oversamples rx_in with a runtime prescale, recovers each bit by 3-sample majority vote, and supports configurable data width, optional even/odd parity, and one or two stop bits. It adds break detection and per-frame configuration latching. It sits in the RX clock domain and feeds the system register/FIFO path with p_data and a single-cycle data_valid strobe.

---
 rtl/uart_rx_cfg.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Oversampling UART receiver with 3-sample majority vote,
//                runtime prescale, optional parity, 1/2 stop bits and break
//                detection. Frame configuration is latched at the start edge.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  break_detect
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_BREAK  = 3'd5;

    localparam logic [3:0]            c_LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] c_MIN_P    = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] c_ONE      = PRESCALE_W'(1);

    logic [2:0]            r_state;
    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] r_p;
    logic [3:0]            r_bit_cnt;
    logic                  r_stop_idx;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_bit;
    logic                  r_brk_cand;
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_parity_error;
    logic                  r_stop_error;
    logic                  r_break_detect;

    logic [PRESCALE_W-1:0] w_p_eff;
    logic [PRESCALE_W-1:0] w_half;
    logic                  w_at_s0;
    logic                  w_at_s1;
    logic                  w_at_vote;
    logic                  w_at_last;
    logic                  w_vote;
    logic                  w_par_exp;
    logic                  w_stop_err;

    // Short ratios are clamped to 8; odd ratios round down to keep P/2 exact.
    assign w_p_eff    = (prescale < c_MIN_P) ? c_MIN_P : {prescale[PRESCALE_W-1:1], 1'b0};
    assign w_half     = r_p >> 1;
    assign w_at_s0    = (r_cnt == w_half - c_ONE);
    assign w_at_s1    = (r_cnt == w_half);
    assign w_at_vote  = (r_cnt == w_half + c_ONE);
    assign w_at_last  = (r_cnt == r_p - c_ONE);
    assign w_vote     = (r_s0 & r_s1) | (r_s0 & rx_in) | (r_s1 & rx_in);
    assign w_par_exp  = (^r_shadow) ^ r_par_typ;
    assign w_stop_err = r_stop_error | ~r_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_cnt          <= '0;
            r_p            <= '0;
            r_bit_cnt      <= '0;
            r_stop_idx     <= 1'b0;
            r_par_en       <= 1'b0;
            r_par_typ      <= 1'b0;
            r_stop2        <= 1'b0;
            r_s0           <= 1'b1;
            r_s1           <= 1'b1;
            r_bit          <= 1'b1;
            r_brk_cand     <= 1'b0;
            r_shadow       <= '0;
            r_p_data       <= '0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
            r_break_detect <= 1'b0;
        end else begin
            r_data_valid   <= 1'b0;
            r_break_detect <= 1'b0;
            if (w_at_s0)   r_s0  <= rx_in;
            if (w_at_s1)   r_s1  <= rx_in;
            if (w_at_vote) r_bit <= w_vote;
            r_cnt <= w_at_last ? '0 : r_cnt + c_ONE;

            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (!rx_in) begin
                        // This cycle is edge 0 of the start bit.
                        r_state   <= c_START;
                        r_cnt     <= c_ONE;
                        r_p       <= w_p_eff;
                        r_par_en  <= par_en;
                        r_par_typ <= par_typ;
                        r_stop2   <= stop2;
                    end
                end
                c_START: begin
                    if (w_at_vote) begin
                        if (w_vote) begin
                            r_state <= c_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_parity_error <= 1'b0;
                            r_stop_error   <= 1'b0;
                            r_brk_cand     <= 1'b1;
                            r_bit_cnt      <= '0;
                            r_stop_idx     <= 1'b0;
                        end
                    end else if (w_at_last) begin
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_at_vote) begin
                        r_shadow <= {w_vote, r_shadow[DATA_WIDTH-1:1]};
                        if (w_vote) r_brk_cand <= 1'b0;
                    end
                    if (w_at_last) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? c_PARITY : c_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                c_PARITY: begin
                    if (w_at_vote && w_vote) r_brk_cand <= 1'b0;
                    if (w_at_last) begin
                        if (r_bit != w_par_exp) r_parity_error <= 1'b1;
                        r_state <= c_STOP;
                    end
                end
                c_STOP: begin
                    if (w_at_vote && w_vote && !r_stop_idx) r_brk_cand <= 1'b0;
                    if (w_at_last) begin
                        r_stop_error <= w_stop_err;
                        if (r_stop_idx == r_stop2) begin
                            r_stop_idx <= 1'b0;
                            if (r_brk_cand) begin
                                r_state        <= c_BREAK;
                                r_break_detect <= 1'b1;
                            end else begin
                                r_state <= c_IDLE;
                                if (!w_stop_err && !r_parity_error) begin
                                    r_p_data     <= r_shadow;
                                    r_data_valid <= 1'b1;
                                end
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                c_BREAK: begin
                    r_cnt <= '0;
                    if (rx_in) r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign p_data       = r_p_data;
    assign data_valid   = r_data_valid;
    assign parity_error = r_parity_error;
    assign stop_error   = r_stop_error;
    assign break_detect = r_break_detect;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Self-checking bench for uart_rx_cfg: vector table, directed
//                corner sequences and random frames against a frame model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int DATA_WIDTH = 8;
    localparam int PRESCALE_W = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  rx_in = 1'b1;
    logic [PRESCALE_W-1:0] prescale = 6'd8;
    logic                  par_en = 1'b0;
    logic                  par_typ = 1'b0;
    logic                  stop2 = 1'b0;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  break_detect;

    uart_rx_cfg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .stop2        (stop2),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .break_detect (break_detect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] ps;
        bit         pe;
        bit         pt;
        bit         s2;
        logic [7:0] data;
        bit         par_bit;
        bit [1:0]   stops;      // [0] first stop bit, [1] second
        logic [5:0] scr_ps;     // prescale driven mid-frame
        int         gap;        // idle-high slots before the start bit
        bit         exp_dv;
        bit         exp_perr;
        bit         exp_serr;
        bit         exp_brk;
        logic [7:0] exp_pdata;
    } frame_t;

    int n_pass = 0;
    int n_total = 0;
    int n_dv = 0;
    int n_brk = 0;
    int n_dv_exp = 0;
    int n_brk_exp = 0;
    bit dv_q = 1'b0;
    bit brk_q = 1'b0;

    logic [7:0] m_pdata = 8'h00;
    bit         m_perr = 1'b0;
    bit         m_serr = 1'b0;
    bit         prev_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Strobes must be single-cycle and are tallied against the expected count.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) n_dv++;
            if (break_detect) n_brk++;
            if (data_valid && dv_q) begin
                n_total++;
                $display("FAIL dv_width: data_valid high 2 cycles, required 1");
            end
            if (break_detect && brk_q) begin
                n_total++;
                $display("FAIL brk_width: break_detect high 2 cycles, required 1");
            end
        end
        dv_q  = data_valid;
        brk_q = break_detect;
    end

    function automatic frame_t expect_of(frame_t f, logic [7:0] held);
        bit par_ok;
        bit stop_ok;
        par_ok      = !f.pe || (f.par_bit == ((^f.data) ^ f.pt));
        stop_ok     = f.stops[0] && (!f.s2 || f.stops[1]);
        f.exp_brk   = (f.data == 8'h00) && (!f.pe || !f.par_bit) && !f.stops[0];
        f.exp_dv    = par_ok && stop_ok;
        f.exp_perr  = !par_ok;
        f.exp_serr  = !stop_ok;
        f.exp_pdata = f.exp_dv ? f.data : held;
        return f;
    endfunction

    // Called at a negedge; returns at the negedge where the strobe is due.
    task automatic send_frame(input frame_t f, input string name);
        int p;
        bit bits[$];
        p = (f.ps < 6'd8) ? 8 : int'(f.ps & 6'h3e);
        repeat (f.gap) begin
            rx_in = 1'b1;
            @(negedge clk);
        end
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_WIDTH; i++) bits.push_back(f.data[i]);
        if (f.pe) bits.push_back(f.par_bit);
        bits.push_back(f.stops[0]);
        if (f.s2) bits.push_back(f.stops[1]);
        prescale = f.ps;
        par_en   = f.pe;
        par_typ  = f.pt;
        stop2    = f.s2;
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < p; k++) begin
                rx_in = bits[b];
                if (b == 0 && k == 1) begin
                    prescale = f.scr_ps;
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                    stop2    = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        check({name, " data_valid"}, 32'(data_valid), 32'(f.exp_dv));
        check({name, " break_detect"}, 32'(break_detect), 32'(f.exp_brk));
        check({name, " parity_error"}, 32'(parity_error), 32'(f.exp_perr));
        check({name, " stop_error"}, 32'(stop_error), 32'(f.exp_serr));
        check({name, " p_data"}, 32'(p_data), 32'(f.exp_pdata));
        if (f.exp_dv) n_dv_exp++;
        if (f.exp_brk) n_brk_exp++;
        m_pdata  = f.exp_pdata;
        m_perr   = f.exp_perr;
        m_serr   = f.exp_serr;
        prev_brk = f.exp_brk;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t tbl[10];
        frame_t f;

        //          ps    pe pt s2 data   par stops  scr    gap dv pe se bk pdata
        tbl[0] = '{6'd8,  1, 0, 0, 8'hA5, 0, 2'b11, 6'd32, 2,  1, 0, 0, 0, 8'hA5};
        tbl[1] = '{6'd8,  1, 0, 0, 8'hA5, 1, 2'b11, 6'd8,  0,  0, 1, 0, 0, 8'hA5};
        tbl[2] = '{6'd8,  1, 0, 0, 8'h3C, 0, 2'b11, 6'd0,  0,  1, 0, 0, 0, 8'h3C};
        tbl[3] = '{6'd16, 0, 0, 1, 8'h77, 0, 2'b01, 6'd5,  0,  0, 0, 1, 0, 8'h3C};
        tbl[4] = '{6'd16, 0, 0, 1, 8'h01, 0, 2'b11, 6'd63, 1,  1, 0, 0, 0, 8'h01};
        tbl[5] = '{6'd9,  1, 1, 0, 8'hF0, 1, 2'b01, 6'd2,  0,  1, 0, 0, 0, 8'hF0};
        tbl[6] = '{6'd3,  0, 0, 0, 8'h00, 0, 2'b10, 6'd40, 0,  0, 0, 1, 1, 8'hF0};
        tbl[7] = '{6'd33, 1, 0, 1, 8'h81, 0, 2'b11, 6'd8,  1,  1, 0, 0, 0, 8'h81};
        tbl[8] = '{6'd8,  1, 1, 0, 8'h00, 0, 2'b11, 6'd8,  0,  0, 1, 0, 0, 8'h81};
        tbl[9] = '{6'd8,  1, 1, 1, 8'h00, 0, 2'b10, 6'd20, 0,  0, 1, 1, 1, 8'h81};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset p_data", 32'(p_data), 32'h0);
        check("reset data_valid", 32'(data_valid), 32'h0);
        check("reset parity_error", 32'(parity_error), 32'h0);
        check("reset stop_error", 32'(stop_error), 32'h0);
        check("reset break_detect", 32'(break_detect), 32'h0);

        for (int i = 0; i < 10; i++) send_frame(tbl[i], $sformatf("tbl%0d", i));

        // Line held low for two frame times: one break, then quiet until release.
        f = '{6'd8, 1, 0, 0, 8'h00, 0, 2'b00, 6'd12, 2, 0, 0, 0, 0, 8'h00};
        send_frame(expect_of(f, m_pdata), "long_break");
        rx_in = 1'b0;
        repeat (88) @(negedge clk);
        f = '{6'd8, 1, 0, 0, 8'h5A, 0, 2'b11, 6'd8, 1, 0, 0, 0, 0, 8'h00};
        send_frame(expect_of(f, m_pdata), "after_break");

        // Three-cycle glitch must not start a frame or touch the flags.
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        prescale = 6'd8;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch parity_error", 32'(parity_error), 32'(m_perr));
        check("glitch stop_error", 32'(stop_error), 32'(m_serr));
        check("glitch p_data", 32'(p_data), 32'(m_pdata));

        // Reset in the middle of the data bits of 0x55.
        prescale = 6'd8;
        par_en   = 1'b0;
        stop2    = 1'b0;
        rx_in    = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            rx_in = (b % 2 == 0);
            repeat (8) @(negedge clk);
        end
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check("midrst p_data", 32'(p_data), 32'h0);
        check("midrst data_valid", 32'(data_valid), 32'h0);
        check("midrst parity_error", 32'(parity_error), 32'h0);
        check("midrst stop_error", 32'(stop_error), 32'h0);
        check("midrst break_detect", 32'(break_detect), 32'h0);
        rst = 1'b0;
        m_pdata = 8'h00;
        f = '{6'd8, 0, 0, 0, 8'h81, 0, 2'b11, 6'd32, 2, 0, 0, 0, 0, 8'h00};
        send_frame(expect_of(f, m_pdata), "post_reset");

        for (int n = 0; n < 40; n++) begin
            f.ps     = 6'($urandom_range(0, 40));
            f.pe     = 1'($urandom);
            f.pt     = 1'($urandom);
            f.s2     = 1'($urandom);
            f.data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            f.par_bit = (^f.data) ^ f.pt;
            if ($urandom_range(0, 3) == 0) f.par_bit = ~f.par_bit;
            f.stops[0] = ($urandom_range(0, 4) != 0);
            f.stops[1] = ($urandom_range(0, 4) != 0);
            f.scr_ps = 6'($urandom);
            f.gap    = prev_brk ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            send_frame(expect_of(f, m_pdata), $sformatf("rnd%0d", n));
        end

        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("data_valid count", 32'(n_dv), 32'(n_dv_exp));
        check("break_detect count", 32'(n_brk), 32'(n_brk_exp));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
